// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one single-master memory bus between an instruction-fetch port and
// a load/store port. Each port holds at most one request, latched on its
// start pulse. Data requests win arbitration, except that a fetch may not be
// passed over more than FETCH_STARVE_MAX times in a row. A fetch can be
// flushed: while still waiting it is dropped, and once on the bus its
// transfer runs to completion but its ready pulse is withheld.

module core_mem_arbiter #(
  parameter int unsigned FETCH_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        fetch_start,
  input  logic [29:0] fetch_addr,
  input  logic        fetch_flush,
  output logic        fetch_ready,
  output logic        fetch_fault,
  output logic [31:0] fetch_data,
  // load/store port
  input  logic        data_start,
  input  logic        data_write,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_be,
  output logic        data_ready,
  output logic        data_fault,
  output logic [31:0] data_rd,
  // memory bus
  output logic [29:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_data_wr,
  output logic [3:0]  bus_be,
  input  logic        bus_waitrequest,
  input  logic [1:0]  bus_response,
  input  logic [31:0] bus_data_rd
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_DATA  = 2'd2
  } state_e;

  localparam logic [2:0] STARVE_MAX = 3'(FETCH_STARVE_MAX);

  // Next starve count after a data grant that passed over a waiting fetch;
  // saturates so the counter never goes past the configured limit.
  function automatic logic [2:0] starve_inc(input logic [2:0] cnt);
    logic [2:0] nxt_s;
    if (cnt >= STARVE_MAX) begin
      nxt_s = STARVE_MAX;
    end else begin
      nxt_s = cnt + 3'd1;
    end
    return nxt_s;
  endfunction

  // Any non-zero bus response is an error.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    return (resp != 2'b00);
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e      state_q, state_d;

  logic        fetch_pend_q, fetch_pend_d;
  logic [29:0] fetch_addr_q, fetch_addr_d;
  logic        fetch_kill_q, fetch_kill_d;   // in-flight fetch was flushed

  logic        data_pend_q, data_pend_d;
  logic        data_write_q, data_write_d;
  logic [29:0] data_addr_q, data_addr_d;
  logic [31:0] data_wr_q, data_wr_d;
  logic [3:0]  data_be_q, data_be_d;

  logic [2:0]  starve_q, starve_d;

  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_wr_q, bus_data_wr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        bus_wr_kind_q, bus_wr_kind_d;  // current transfer is a store
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;

  logic        fetch_ready_q, fetch_ready_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic        data_ready_q, data_ready_d;
  logic        data_fault_q, data_fault_d;
  logic [31:0] data_rd_q, data_rd_d;

  // ---------------------------------------------------------------------
  // Request bookkeeping
  // ---------------------------------------------------------------------
  logic        fetch_busy_s;
  logic        data_busy_s;
  logic        fetch_acc_s;
  logic        fetch_old_s;
  logic        fetch_req_s;
  logic [29:0] fetch_req_addr_s;
  logic        data_acc_s;
  logic        data_req_s;
  logic        data_req_write_s;
  logic [29:0] data_req_addr_s;
  logic [31:0] data_req_wr_s;
  logic [3:0]  data_req_be_s;
  logic        bus_fault_s;

  assign fetch_busy_s = (state_q == BUS_FETCH);
  assign data_busy_s  = (state_q == BUS_DATA);

  // A flush only hits fetches already held, so a start arriving with the
  // flush is always taken and replaces whatever was waiting.
  assign fetch_acc_s      = fetch_start & (fetch_flush | (~fetch_pend_q & ~fetch_busy_s));
  assign fetch_old_s      = fetch_pend_q & ~fetch_flush;
  assign fetch_req_s      = fetch_old_s | fetch_acc_s;
  assign fetch_req_addr_s = fetch_acc_s ? fetch_addr : fetch_addr_q;

  assign data_acc_s       = data_start & ~data_pend_q & ~data_busy_s;
  assign data_req_s       = data_pend_q | data_acc_s;
  assign data_req_write_s = data_acc_s ? data_write : data_write_q;
  assign data_req_addr_s  = data_acc_s ? data_addr  : data_addr_q;
  assign data_req_wr_s    = data_acc_s ? data_wr    : data_wr_q;
  assign data_req_be_s    = data_acc_s ? data_be    : data_be_q;

  assign bus_fault_s = resp_is_fault(bus_response);

  // Next-state, arbitration, bus setup and completion reporting.
  always_comb begin
    state_d       = state_q;
    fetch_pend_d  = fetch_req_s;
    fetch_addr_d  = fetch_req_addr_s;
    fetch_kill_d  = fetch_kill_q | (fetch_busy_s & fetch_flush);
    data_pend_d   = data_req_s;
    data_write_d  = data_req_write_s;
    data_addr_d   = data_req_addr_s;
    data_wr_d     = data_req_wr_s;
    data_be_d     = data_req_be_s;
    starve_d      = fetch_req_s ? starve_q : 3'd0;
    bus_addr_d    = bus_addr_q;
    bus_data_wr_d = bus_data_wr_q;
    bus_be_d      = bus_be_q;
    bus_wr_kind_d = bus_wr_kind_q;
    fetch_ready_d = 1'b0;
    fetch_fault_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    data_ready_d  = 1'b0;
    data_fault_d  = 1'b0;
    data_rd_d     = data_rd_q;

    case (state_q)
      IDLE: begin
        if (data_req_s && (!fetch_req_s || (starve_q != STARVE_MAX))) begin
          state_d       = BUS_DATA;
          data_pend_d   = 1'b0;
          bus_addr_d    = data_req_addr_s;
          bus_data_wr_d = data_req_wr_s;
          bus_be_d      = data_req_be_s;
          bus_wr_kind_d = data_req_write_s;
          if (fetch_req_s) begin
            starve_d = starve_inc(starve_q);
          end else begin
            starve_d = 3'd0;
          end
        end else if (fetch_req_s) begin
          state_d       = BUS_FETCH;
          fetch_pend_d  = 1'b0;
          fetch_kill_d  = 1'b0;
          bus_addr_d    = fetch_req_addr_s;
          bus_data_wr_d = 32'd0;
          bus_be_d      = 4'b1111;
          bus_wr_kind_d = 1'b0;
          starve_d      = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      BUS_FETCH: begin
        if (!bus_waitrequest) begin
          state_d      = IDLE;
          fetch_kill_d = 1'b0;
          if (!fetch_kill_q && !fetch_flush) begin
            fetch_ready_d = 1'b1;
            fetch_fault_d = bus_fault_s;
            fetch_data_d  = bus_fault_s ? 32'd0 : bus_data_rd;
          end else begin
            fetch_ready_d = 1'b0;
          end
        end else begin
          state_d = BUS_FETCH;
        end
      end

      BUS_DATA: begin
        if (!bus_waitrequest) begin
          state_d      = IDLE;
          data_ready_d = 1'b1;
          data_fault_d = bus_fault_s;
          data_rd_d    = (bus_fault_s || bus_wr_kind_q) ? 32'd0 : bus_data_rd;
        end else begin
          state_d = BUS_DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    bus_read_d  = (state_d == BUS_FETCH) || ((state_d == BUS_DATA) && !bus_wr_kind_d);
    bus_write_d = (state_d == BUS_DATA) && bus_wr_kind_d;
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pend_q  <= 1'b0;
      fetch_addr_q  <= 30'd0;
      fetch_kill_q  <= 1'b0;
      data_pend_q   <= 1'b0;
      data_write_q  <= 1'b0;
      data_addr_q   <= 30'd0;
      data_wr_q     <= 32'd0;
      data_be_q     <= 4'd0;
      starve_q      <= 3'd0;
      bus_addr_q    <= 30'd0;
      bus_data_wr_q <= 32'd0;
      bus_be_q      <= 4'd0;
      bus_wr_kind_q <= 1'b0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      fetch_ready_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_data_q  <= 32'd0;
      data_ready_q  <= 1'b0;
      data_fault_q  <= 1'b0;
      data_rd_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pend_q  <= fetch_pend_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_kill_q  <= fetch_kill_d;
      data_pend_q   <= data_pend_d;
      data_write_q  <= data_write_d;
      data_addr_q   <= data_addr_d;
      data_wr_q     <= data_wr_d;
      data_be_q     <= data_be_d;
      starve_q      <= starve_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_wr_q <= bus_data_wr_d;
      bus_be_q      <= bus_be_d;
      bus_wr_kind_q <= bus_wr_kind_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      fetch_ready_q <= fetch_ready_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_data_q  <= fetch_data_d;
      data_ready_q  <= data_ready_d;
      data_fault_q  <= data_fault_d;
      data_rd_q     <= data_rd_d;
    end
  end

  assign fetch_ready = fetch_ready_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_data  = fetch_data_q;
  assign data_ready  = data_ready_q;
  assign data_fault  = data_fault_q;
  assign data_rd     = data_rd_q;
  assign bus_addr    = bus_addr_q;
  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_data_wr = bus_data_wr_q;
  assign bus_be      = bus_be_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios followed by a randomized
// run scored against a transaction-level model of the two ports and the bus.

module tb_core_mem_arbiter;

  localparam int unsigned MAX = 4;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic [29:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_ready;
  logic        fetch_fault;
  logic [31:0] fetch_data;
  logic        data_start;
  logic        data_write;
  logic [29:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_be;
  logic        data_ready;
  logic        data_fault;
  logic [31:0] data_rd;
  logic [29:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_be;
  logic        bus_waitrequest;
  logic [1:0]  bus_response;
  logic [31:0] bus_data_rd;

  int checks = 0;
  int errors = 0;

  core_mem_arbiter #(.FETCH_STARVE_MAX(MAX)) dut (
    .clk(clk), .rst(rst),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_ready(fetch_ready), .fetch_fault(fetch_fault), .fetch_data(fetch_data),
    .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
    .data_wr(data_wr), .data_be(data_be),
    .data_ready(data_ready), .data_fault(data_fault), .data_rd(data_rd),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_be(bus_be),
    .bus_waitrequest(bus_waitrequest), .bus_response(bus_response),
    .bus_data_rd(bus_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_starts();
    fetch_start = 1'b0;
    data_start  = 1'b0;
    fetch_flush = 1'b0;
  endtask

  task automatic start_fetch(input logic [29:0] a);
    fetch_start = 1'b1;
    fetch_addr  = a;
  endtask

  task automatic start_data(input logic wr, input logic [29:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    data_start = 1'b1;
    data_write = wr;
    data_addr  = a;
    data_wr    = d;
    data_be    = be;
  endtask

  // transaction-level model state for the random run
  logic        m_fw, m_fout, m_fkill, m_dw, m_dout, m_dwr;
  logic [29:0] m_fa, m_da;
  logic [31:0] m_dd;
  logic [3:0]  m_dbe;
  logic [1:0]  m_bus;                // 0 none, 1 fetch, 2 data
  int unsigned m_starve;
  logic [29:0] b_addr;
  logic        b_wr;
  logic [31:0] b_data;
  logic [3:0]  b_be;
  logic        exp_fr, exp_ff, exp_dr, exp_df, flt;
  logic [31:0] exp_fd, exp_dd;
  int unsigned r;

  initial begin
    rst = 1'b1;
    clear_starts();
    fetch_addr = 30'd0; data_write = 1'b0; data_addr = 30'd0;
    data_wr = 32'd0; data_be = 4'd0;
    bus_waitrequest = 1'b0; bus_response = 2'b00; bus_data_rd = 32'd0;

    // reset state
    @(negedge clk); @(negedge clk);
    check("rst bus_read", 32'(bus_read), 32'd0);
    check("rst bus_write", 32'(bus_write), 32'd0);
    check("rst fetch_ready", 32'(fetch_ready), 32'd0);
    check("rst data_ready", 32'(data_ready), 32'd0);
    check("rst bus_addr", 32'(bus_addr), 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    rst = 1'b0;

    // single fetch, no wait states
    @(negedge clk); start_fetch(30'h100);
    @(negedge clk); clear_starts();
    check("f1 bus_read", 32'(bus_read), 32'd1);
    check("f1 bus_write", 32'(bus_write), 32'd0);
    check("f1 bus_addr", 32'(bus_addr), 32'h100);
    check("f1 bus_be", 32'(bus_be), 32'hF);
    bus_data_rd = 32'hDEADBEEF;
    @(negedge clk);
    check("f1 fetch_ready", 32'(fetch_ready), 32'd1);
    check("f1 fetch_data", fetch_data, 32'hDEADBEEF);
    check("f1 fetch_fault", 32'(fetch_fault), 32'd0);
    check("f1 strobe low", 32'(bus_read), 32'd0);
    @(negedge clk);
    check("f1 ready pulse", 32'(fetch_ready), 32'd0);

    // simultaneous store and fetch: store first, one idle cycle, then fetch
    start_fetch(30'h200); start_data(1'b1, 30'h300, 32'h12345678, 4'b0011);
    @(negedge clk); clear_starts();
    check("both bus_write", 32'(bus_write), 32'd1);
    check("both bus_read", 32'(bus_read), 32'd0);
    check("both addr", 32'(bus_addr), 32'h300);
    check("both wdata", bus_data_wr, 32'h12345678);
    check("both be", 32'(bus_be), 32'h3);
    @(negedge clk);
    check("both gap read", 32'(bus_read), 32'd0);
    check("both gap write", 32'(bus_write), 32'd0);
    check("both data_ready", 32'(data_ready), 32'd1);
    check("both store rd", data_rd, 32'd0);
    bus_data_rd = 32'hCAFEF00D;
    @(negedge clk);
    check("both fetch read", 32'(bus_read), 32'd1);
    check("both fetch addr", 32'(bus_addr), 32'h200);
    @(negedge clk);
    check("both fetch_ready", 32'(fetch_ready), 32'd1);
    check("both fetch_data", fetch_data, 32'hCAFEF00D);

    // starvation bound: 4 data grants, then the waiting fetch, then data 5
    @(negedge clk);
    bus_data_rd = 32'h0BADF00D;
    start_fetch(30'h040); start_data(1'b0, 30'h2000_0001, 32'd0, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); clear_starts();
      check("starve data addr", 32'(bus_addr), 32'h2000_0000 + 32'(k));
      @(negedge clk);
      check("starve data_ready", 32'(data_ready), 32'd1);
      check("starve fetch idle", 32'(fetch_ready), 32'd0);
      start_data(1'b0, 30'h2000_0000 + 30'(k + 1), 32'd0, 4'hF);
    end
    @(negedge clk); clear_starts();
    check("starve fetch wins", 32'(bus_addr), 32'h040);
    check("starve fetch read", 32'(bus_be), 32'hF);
    @(negedge clk);
    check("starve fetch_ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    check("starve data5 addr", 32'(bus_addr), 32'h2000_0005);
    @(negedge clk);
    check("starve data5 ready", 32'(data_ready), 32'd1);
    check("starve data5 rd", data_rd, 32'h0BADF00D);

    // flush during a stalled fetch: transfer finishes, no ready
    @(negedge clk); start_fetch(30'h080);
    @(negedge clk); clear_starts();
    check("flush bus_read", 32'(bus_read), 32'd1);
    bus_waitrequest = 1'b1; fetch_flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); fetch_flush = 1'b0;
      check("flush hold read", 32'(bus_read), 32'd1);
      check("flush hold addr", 32'(bus_addr), 32'h080);
    end
    bus_waitrequest = 1'b0;
    @(negedge clk);
    check("flush done strobe", 32'(bus_read), 32'd0);
    check("flush no ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    check("flush no ready 2", 32'(fetch_ready), 32'd0);

    // flush + start together: older pending fetch dropped, new one served
    start_data(1'b1, 30'h2000_0100, 32'h1, 4'hF);
    @(negedge clk); clear_starts(); bus_waitrequest = 1'b1; start_fetch(30'h0A0);
    @(negedge clk); start_fetch(30'h0B0); fetch_flush = 1'b1;
    @(negedge clk); clear_starts(); bus_waitrequest = 1'b0;
    @(negedge clk);
    check("fs data_ready", 32'(data_ready), 32'd1);
    check("fs gap", 32'(bus_read), 32'd0);
    @(negedge clk);
    check("fs new fetch", 32'(bus_read), 32'd1);
    check("fs new addr", 32'(bus_addr), 32'h0B0);
    @(negedge clk);
    check("fs fetch_ready", 32'(fetch_ready), 32'd1);

    // flush alone drops a pending fetch entirely
    @(negedge clk); start_data(1'b0, 30'h2000_0200, 32'd0, 4'hF);
    @(negedge clk); clear_starts(); bus_waitrequest = 1'b1; start_fetch(30'h0C0);
    @(negedge clk); clear_starts(); fetch_flush = 1'b1;
    @(negedge clk); clear_starts(); bus_waitrequest = 1'b0;
    @(negedge clk);
    check("fd data_ready", 32'(data_ready), 32'd1);
    @(negedge clk);
    check("fd no fetch", 32'(bus_read), 32'd0);
    @(negedge clk);
    check("fd no ready", 32'(fetch_ready), 32'd0);
    check("fd still idle", 32'(bus_read), 32'd0);

    // load with error response
    start_data(1'b0, 30'h2000_4000, 32'd0, 4'hF);
    @(negedge clk); clear_starts();
    check("err bus_read", 32'(bus_read), 32'd1);
    bus_response = 2'b10; bus_data_rd = 32'hFFFFFFFF;
    @(negedge clk); bus_response = 2'b00;
    check("err data_ready", 32'(data_ready), 32'd1);
    check("err data_fault", 32'(data_fault), 32'd1);
    check("err data_rd", data_rd, 32'd0);

    // reset during a stalled store; start in reset cycle discarded
    @(negedge clk); start_data(1'b1, 30'h2000_5000, 32'h77, 4'hF);
    @(negedge clk); clear_starts(); bus_waitrequest = 1'b1;
    check("rd bus_write", 32'(bus_write), 32'd1);
    @(negedge clk); rst = 1'b1; start_fetch(30'h111);
    @(negedge clk); rst = 1'b0; clear_starts(); bus_waitrequest = 1'b0;
    check("rd write dropped", 32'(bus_write), 32'd0);
    check("rd read low", 32'(bus_read), 32'd0);
    check("rd no data_ready", 32'(data_ready), 32'd0);
    @(negedge clk);
    check("rd start discarded", 32'(bus_read), 32'd0);
    check("rd no data_ready 2", 32'(data_ready), 32'd0);
    start_data(1'b0, 30'h2000_6000, 32'd0, 4'hF); bus_data_rd = 32'h13579BDF;
    @(negedge clk); clear_starts();
    check("rd fresh addr", 32'(bus_addr), 32'h2000_6000);
    check("rd fresh read", 32'(bus_read), 32'd1);
    @(negedge clk);
    check("rd fresh ready", 32'(data_ready), 32'd1);
    check("rd fresh rd", data_rd, 32'h13579BDF);

    // randomized run against the model
    rst = 1'b1; clear_starts(); bus_waitrequest = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_fw = 1'b0; m_fout = 1'b0; m_fkill = 1'b0; m_dw = 1'b0; m_dout = 1'b0;
    m_dwr = 1'b0; m_fa = 30'd0; m_da = 30'd0; m_dd = 32'd0; m_dbe = 4'd0;
    m_bus = 2'd0; m_starve = 0;
    b_addr = 30'd0; b_wr = 1'b0; b_data = 32'd0; b_be = 4'd0;
    exp_fr = 1'b0; exp_ff = 1'b0; exp_fd = 32'd0;
    exp_dr = 1'b0; exp_df = 1'b0; exp_dd = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check("rnd fetch_ready", 32'(fetch_ready), 32'(exp_fr));
      if (exp_fr) begin
        check("rnd fetch_fault", 32'(fetch_fault), 32'(exp_ff));
        check("rnd fetch_data", fetch_data, exp_fd);
      end
      check("rnd data_ready", 32'(data_ready), 32'(exp_dr));
      if (exp_dr) begin
        check("rnd data_fault", 32'(data_fault), 32'(exp_df));
        check("rnd data_rd", data_rd, exp_dd);
      end
      check("rnd ready excl", 32'(fetch_ready & data_ready), 32'd0);
      check("rnd bus_read", 32'(bus_read),
            32'((m_bus == 2'd1) || ((m_bus == 2'd2) && !b_wr)));
      check("rnd bus_write", 32'(bus_write), 32'((m_bus == 2'd2) && b_wr));
      if (m_bus != 2'd0) begin
        check("rnd bus_addr", 32'(bus_addr), 32'(b_addr));
        check("rnd bus_be", 32'(bus_be), 32'(b_be));
        if (b_wr) check("rnd bus_data_wr", bus_data_wr, b_data);
      end

      clear_starts();
      exp_fr = 1'b0;
      exp_dr = 1'b0;
      if (m_fout && !m_fkill && ($urandom_range(0, 19) == 0)) begin
        fetch_flush = 1'b1;
        if (m_fw) begin
          m_fw = 1'b0;
          m_fout = 1'b0;
        end else begin
          m_fkill = 1'b1;
        end
      end
      if (!fetch_flush && !m_fout && ($urandom_range(0, 2) == 0)) begin
        r = $urandom();
        start_fetch({1'b0, r[28:0]});
        m_fw = 1'b1; m_fout = 1'b1; m_fa = {1'b0, r[28:0]};
      end
      if (!m_dout && ($urandom_range(0, 2) == 0)) begin
        r = $urandom();
        m_dwr = r[31]; m_da = {1'b1, r[28:0]}; m_dd = $urandom(); m_dbe = r[3:0];
        start_data(m_dwr, m_da, m_dd, m_dbe);
        m_dw = 1'b1; m_dout = 1'b1;
      end
      bus_waitrequest = ($urandom_range(0, 2) == 0);
      r = $urandom();
      bus_response = ($urandom_range(0, 3) == 0) ? r[1:0] : 2'b00;
      bus_data_rd = $urandom();

      if (m_bus != 2'd0) begin
        if (!bus_waitrequest) begin
          flt = (bus_response != 2'b00);
          if (m_bus == 2'd1) begin
            if (!m_fkill) begin
              exp_fr = 1'b1; exp_ff = flt; exp_fd = flt ? 32'd0 : bus_data_rd;
            end
            m_fkill = 1'b0;
            m_fout = 1'b0;
          end else begin
            exp_dr = 1'b1; exp_df = flt;
            exp_dd = (flt || b_wr) ? 32'd0 : bus_data_rd;
            m_dout = 1'b0;
          end
          m_bus = 2'd0;
        end
        if (!m_fw) m_starve = 0;
      end else if (m_dw && (!m_fw || m_starve != MAX)) begin
        m_starve = m_fw ? ((m_starve < MAX) ? m_starve + 1 : MAX) : 0;
        m_dw = 1'b0; m_bus = 2'd2;
        b_addr = m_da; b_wr = m_dwr; b_data = m_dd; b_be = m_dbe;
      end else if (m_fw) begin
        m_starve = 0; m_fw = 1'b0; m_bus = 2'd1;
        b_addr = m_fa; b_wr = 1'b0; b_data = 32'd0; b_be = 4'hF;
      end else begin
        m_starve = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter FETCH_STARVE_MAX, default 4, range 1..7: max consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port fetch_start  in  1  one-cycle pulse: new instruction fetch request.
REQ-005 SHALL have port fetch_addr  in  30  word address (ptr) of fetch, valid with fetch_start.
REQ-006 SHALL have port fetch_flush  in  1  cancel any fetch not yet completed (branch/exception).
REQ-007 SHALL have port fetch_ready  out  1  one-cycle pulse: fetch completed.
REQ-008 SHALL have port fetch_fault  out  1  fetch bus error, valid with fetch_ready.
REQ-009 SHALL have port fetch_data  out  32  instruction word, valid with fetch_ready.
REQ-010 SHALL have port data_start  in  1  one-cycle pulse: new load/store request.
REQ-011 SHALL have port data_write  in  1  1 = store, 0 = load, valid with data_start.
REQ-012 SHALL have port data_addr  in  30  word address, valid with data_start.
REQ-013 SHALL have port data_wr  in  32  store data, valid with data_start.
REQ-014 SHALL have port data_be  in  4  byte enables, valid with data_start.
REQ-015 SHALL have port data_ready  out  1  one-cycle pulse: load/store completed.
REQ-016 SHALL have port data_fault  out  1  data bus error, valid with data_ready.
REQ-017 SHALL have port data_rd  out  32  load data, valid with data_ready.
REQ-018 SHALL have port bus_addr  out  30  bus word address.
REQ-019 SHALL have port bus_read  out  1  bus read strobe, held until accepted.
REQ-020 SHALL have port bus_write  out  1  bus write strobe, held until accepted.
REQ-021 SHALL have port bus_data_wr  out  32  bus write data.
REQ-022 SHALL have port bus_be  out  4  bus byte enables (4'b1111 for fetch).
REQ-023 SHALL have port bus_waitrequest  in  1  slave stall; transfer completes in a strobe cycle with it low.
REQ-024 SHALL have port bus_response  in  2  2'b00 OK, any other value = fault, sampled at completion.
REQ-025 SHALL have port bus_data_rd  in  32  read data, sampled at completion.

Function
REQ-026 SHALL latch each start's address/data/be/write into a per-port pending register; a start while that port is already pending or on the bus SHALL be ignored.
REQ-027 SHALL implement states IDLE, BUS_FETCH, BUS_DATA; bus_read = BUS_FETCH or (BUS_DATA and not write), bus_write = BUS_DATA and write; strobes 0 in IDLE.
REQ-028 In IDLE, SHALL arbitrate over (pending or start this cycle) per port; a start in IDLE with no competitor SHALL put its strobe on the bus the next cycle.
REQ-029 When both ports request, data SHALL win unless starve counter == FETCH_STARVE_MAX, then fetch SHALL win.
REQ-030 Starve counter (3 bits) SHALL increment on each data grant while a fetch is pending, clear on fetch grant or when no fetch is pending, and never exceed FETCH_STARVE_MAX.
REQ-031 Bus outputs SHALL stay stable while waitrequest is high; on completion state SHALL return to IDLE, giving exactly one strobe-low cycle between transfers.
REQ-032 The cycle after completion, the owning port's ready SHALL pulse for exactly one cycle with fault = (bus_response != 0); read data SHALL be bus_data_rd, or 0 on fault or store.
REQ-033 fetch_flush SHALL clear a pending (not yet granted) fetch; if BUS_FETCH is active, the transfer SHALL finish on the bus but fetch_ready SHALL be suppressed.
REQ-034 fetch_flush and fetch_start in the same cycle: the flush SHALL apply to older fetches only and the new fetch SHALL be accepted.
REQ-035 fetch_ready and data_ready SHALL never assert in the same cycle.

Reset
REQ-036 While rst is high at an edge: state IDLE, pending flags 0, starve counter 0, all outputs 0 the next cycle; any in-flight transfer is abandoned and no ready pulse is emitted.
REQ-037 Starts sampled in the same cycle as rst SHALL be discarded.

Verification
REQ-038 fetch_start addr 0x100 in IDLE, waitrequest low -> bus_read with bus_addr 0x100 next cycle, fetch_ready with bus_data_rd the cycle after.
REQ-039 fetch and data start together, data_write=1, be 4'b0011 -> bus_write first; fetch bus_read after exactly one strobe-low cycle.
REQ-040 fetch pending, 5 back-to-back data requests, MAX=4 -> 4 data grants, then fetch granted, then 5th data.
REQ-041 BUS_FETCH with waitrequest high 3 cycles, fetch_flush asserted -> transfer completes on bus, no fetch_ready.
REQ-042 Load completing with bus_response 2'b10 -> data_ready=1, data_fault=1, data_rd=0.
REQ-043 rst during BUS_DATA with waitrequest high -> strobes 0 next cycle, no data_ready, fresh start then served normally.
